// File: rtl/lsu_mem_master_if.sv
// Bundle of the CPU request/response channels and the data-memory port
// for the load/store initiator. The master modport is the initiator's view.
interface lsu_mem_master_if;
  // CPU request channel
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_len;
  logic        req_sign;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  // CPU response channel
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        resp_split;
  // Data-memory port
  logic        mem_read;
  logic        mem_write;
  logic [1:0]  mem_len;
  logic        mem_sign;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  modport master (
    input  req_valid, req_we, req_len, req_sign, req_addr, req_wdata,
    input  resp_ready, mem_rdata,
    output req_ready, resp_valid, resp_rdata, resp_err, resp_split,
    output mem_read, mem_write, mem_len, mem_sign, mem_addr, mem_wdata
  );

  modport slave (
    output req_valid, req_we, req_len, req_sign, req_addr, req_wdata,
    output resp_ready, mem_rdata,
    input  req_ready, resp_valid, resp_rdata, resp_err, resp_split,
    input  mem_read, mem_write, mem_len, mem_sign, mem_addr, mem_wdata
  );
endinterface

// File: rtl/lsu_mem_master.sv
// Load/store initiator: accepts one CPU request at a time, drives the
// byte-addressed data memory, splits misaligned accesses into little-endian
// byte transactions, rebuilds/extends load data and returns a response.
module lsu_mem_master #(
  parameter int SIZE        = 4096,
  parameter bit ALLOW_SPLIT = 1'b1
) (
  input logic             clk,
  input logic             rst,
  lsu_mem_master_if.master bus
);

  // Access length codes shared with the memory's LSLength input
  localparam logic [1:0] LEN_BYTE = 2'b00;
  localparam logic [1:0] LEN_HALF = 2'b01;
  localparam logic [1:0] LEN_WORD = 2'b10;

  localparam logic [32:0] SIZE_LIM = 33'(SIZE);

  typedef enum logic [1:0] {IDLE, ISSUE, CAPT, RESP} state_t;

  state_t      state_q;
  logic        we_q, sign_q, split_q, err_q;
  logic [1:0]  len_q, k_q, last_k_q;
  logic [31:0] addr_q, wdata_q, buf_q;

  logic        req_ready_q, resp_valid_q, resp_err_q, resp_split_q;
  logic [31:0] resp_rdata_q;
  logic        mem_read_q, mem_write_q, mem_sign_q;
  logic [1:0]  mem_len_q;
  logic [31:0] mem_addr_q, mem_wdata_q;

  logic [2:0]  dec_nbytes;
  logic        dec_len_ok, dec_aligned, dec_oob, dec_err;
  logic [31:0] cap_word, cap_ext;

  // Decode the incoming request: size, alignment, 33-bit bounds check, error
  always_comb begin
    dec_nbytes  = 3'd1;
    dec_len_ok  = 1'b1;
    dec_aligned = 1'b1;
    case (bus.req_len)
      LEN_BYTE: dec_nbytes = 3'd1;
      LEN_HALF: begin
        dec_nbytes  = 3'd2;
        dec_aligned = ~bus.req_addr[0];
      end
      LEN_WORD: begin
        dec_nbytes  = 3'd4;
        dec_aligned = (bus.req_addr[1:0] == 2'b00);
      end
      default: dec_len_ok = 1'b0;
    endcase
    dec_oob = ({1'b0, bus.req_addr} + {30'b0, dec_nbytes}) > SIZE_LIM;
    dec_err = ~dec_len_ok | dec_oob | (~dec_aligned & ~ALLOW_SPLIT);
  end

  // Merge the byte arriving now into lane k of the split-load buffer
  for (genvar gi = 0; gi < 4; gi++) begin : g_cap
    assign cap_word[8*gi +: 8] = (k_q == 2'(gi)) ? bus.mem_rdata[7:0] : buf_q[8*gi +: 8];
  end

  // Split loads only occur for halfwords and words; halfwords need extension
  assign cap_ext = (len_q == LEN_HALF)
                 ? (sign_q ? {{16{cap_word[15]}}, cap_word[15:0]} : {16'b0, cap_word[15:0]})
                 : cap_word;

  // Main FSM with registered outputs; strobes default low so each lasts one cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      we_q         <= 1'b0;
      sign_q       <= 1'b0;
      split_q      <= 1'b0;
      err_q        <= 1'b0;
      len_q        <= LEN_BYTE;
      k_q          <= 2'd0;
      last_k_q     <= 2'd0;
      addr_q       <= 32'd0;
      wdata_q      <= 32'd0;
      buf_q        <= 32'd0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_split_q <= 1'b0;
      resp_rdata_q <= 32'd0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_sign_q   <= 1'b0;
      mem_len_q    <= 2'd0;
      mem_addr_q   <= 32'd0;
      mem_wdata_q  <= 32'd0;
    end else begin
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.req_valid) begin
            we_q        <= bus.req_we;
            sign_q      <= bus.req_sign;
            len_q       <= bus.req_len;
            addr_q      <= bus.req_addr;
            wdata_q     <= bus.req_wdata;
            k_q         <= 2'd0;
            last_k_q    <= 2'(dec_nbytes - 3'd1);
            buf_q       <= 32'd0;
            req_ready_q <= 1'b0;
            // Errors take the issue slot with strobes held low, so the
            // response appears one cycle after accept with no memory access
            state_q     <= ISSUE;
            if (dec_err) begin
              err_q   <= 1'b1;
              split_q <= 1'b0;
            end else begin
              err_q       <= 1'b0;
              split_q     <= ~dec_aligned;
              mem_read_q  <= ~bus.req_we;
              mem_write_q <= bus.req_we;
              mem_addr_q  <= bus.req_addr;
              if (dec_aligned) begin
                mem_len_q   <= bus.req_len;
                mem_sign_q  <= bus.req_sign;
                mem_wdata_q <= bus.req_wdata;
              end else begin
                mem_len_q   <= LEN_BYTE;
                mem_sign_q  <= 1'b0;
                mem_wdata_q <= {24'b0, bus.req_wdata[7:0]};
              end
            end
          end
        end
        ISSUE: begin
          if (err_q) begin
            state_q      <= RESP;
            resp_valid_q <= 1'b1;
            resp_err_q   <= 1'b1;
            resp_split_q <= 1'b0;
            resp_rdata_q <= 32'd0;
          end else if (!we_q) begin
            state_q <= CAPT;
          end else if (!split_q || (k_q == last_k_q)) begin
            state_q      <= RESP;
            resp_valid_q <= 1'b1;
            resp_err_q   <= 1'b0;
            resp_split_q <= split_q;
            resp_rdata_q <= 32'd0;
          end else begin
            k_q         <= k_q + 2'd1;
            mem_write_q <= 1'b1;
            mem_addr_q  <= addr_q + {30'b0, k_q + 2'd1};
            mem_wdata_q <= {24'b0, wdata_q[{k_q + 2'd1, 3'b000} +: 8]};
          end
        end
        CAPT: begin
          if (!split_q) begin
            state_q      <= RESP;
            resp_valid_q <= 1'b1;
            resp_err_q   <= 1'b0;
            resp_split_q <= 1'b0;
            resp_rdata_q <= bus.mem_rdata;
          end else if (k_q == last_k_q) begin
            state_q      <= RESP;
            resp_valid_q <= 1'b1;
            resp_err_q   <= 1'b0;
            resp_split_q <= 1'b1;
            resp_rdata_q <= cap_ext;
          end else begin
            buf_q      <= cap_word;
            k_q        <= k_q + 2'd1;
            mem_read_q <= 1'b1;
            mem_addr_q <= addr_q + {30'b0, k_q + 2'd1};
            state_q    <= ISSUE;
          end
        end
        RESP: begin
          if (bus.resp_ready) begin
            state_q      <= IDLE;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_split_q <= 1'b0;
            resp_rdata_q <= 32'd0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.req_ready  = req_ready_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_rdata = resp_rdata_q;
  assign bus.resp_err   = resp_err_q;
  assign bus.resp_split = resp_split_q;
  assign bus.mem_read   = mem_read_q;
  assign bus.mem_write  = mem_write_q;
  assign bus.mem_len    = mem_len_q;
  assign bus.mem_sign   = mem_sign_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_wdata  = mem_wdata_q;

endmodule

// File: tb/tb_lsu_mem_master.sv
// Testbench for lsu_mem_master: byte-array memory model with one-cycle read
// latency, a vector table of requests, and hand-written handshake/reset sequences.
module tb_lsu_mem_master;

  localparam logic [1:0] B = 2'b00;
  localparam logic [1:0] H = 2'b01;
  localparam logic [1:0] W = 2'b10;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  lsu_mem_master_if bus_if ();

  lsu_mem_master #(.SIZE(4096), .ALLOW_SPLIT(1'b1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if.master)
  );

  // Memory model: byte array, writes per length, reads extended per length/sign
  logic [7:0]  tmem [0:4095];
  bit          init_done;
  logic [31:0] rd_q;
  logic        rd_v;
  int          strb_total;
  logic [31:0] log_addr [0:255];
  logic [7:0]  log_data [0:255];
  logic [1:0]  log_len  [0:255];

  function automatic logic [31:0] mread(input logic [11:0] a, input logic [1:0] len, input logic sgn);
    logic [31:0] v;
    case (len)
      2'b00:   v = sgn ? {{24{tmem[a][7]}}, tmem[a]} : {24'b0, tmem[a]};
      2'b01:   v = sgn ? {{16{tmem[a+12'd1][7]}}, tmem[a+12'd1], tmem[a]}
                       : {16'b0, tmem[a+12'd1], tmem[a]};
      default: v = {tmem[a+12'd3], tmem[a+12'd2], tmem[a+12'd1], tmem[a]};
    endcase
    return v;
  endfunction

  always @(posedge clk) begin
    if (!init_done) begin
      for (int i = 0; i < 4096; i++) tmem[i] <= 8'h00;
      tmem[12'h010] <= 8'hBB; tmem[12'h011] <= 8'hAA;
      tmem[12'h012] <= 8'h99; tmem[12'h013] <= 8'h88;
      tmem[12'h020] <= 8'h55; tmem[12'h021] <= 8'h34;
      tmem[12'h022] <= 8'h92; tmem[12'h023] <= 8'h66;
      tmem[12'hFFF] <= 8'h80;
      init_done <= 1'b1;
    end
    rd_v <= 1'b0;
    if (bus_if.mem_write) begin
      case (bus_if.mem_len)
        2'b00: tmem[bus_if.mem_addr[11:0]] <= bus_if.mem_wdata[7:0];
        2'b01: begin
          tmem[bus_if.mem_addr[11:0]]         <= bus_if.mem_wdata[7:0];
          tmem[bus_if.mem_addr[11:0] + 12'd1] <= bus_if.mem_wdata[15:8];
        end
        default: begin
          tmem[bus_if.mem_addr[11:0]]         <= bus_if.mem_wdata[7:0];
          tmem[bus_if.mem_addr[11:0] + 12'd1] <= bus_if.mem_wdata[15:8];
          tmem[bus_if.mem_addr[11:0] + 12'd2] <= bus_if.mem_wdata[23:16];
          tmem[bus_if.mem_addr[11:0] + 12'd3] <= bus_if.mem_wdata[31:24];
        end
      endcase
    end
    if (bus_if.mem_read) begin
      rd_q <= mread(bus_if.mem_addr[11:0], bus_if.mem_len, bus_if.mem_sign);
      rd_v <= 1'b1;
    end
    if (bus_if.mem_read || bus_if.mem_write) begin
      log_addr[strb_total[7:0]] <= bus_if.mem_addr;
      log_data[strb_total[7:0]] <= bus_if.mem_wdata[7:0];
      log_len[strb_total[7:0]]  <= bus_if.mem_len;
      strb_total <= strb_total + 1;
    end
  end

  assign bus_if.mem_rdata = rd_v ? rd_q : 32'hzzzz_zzzz;

  // Checking
  int n_checks = 0;
  int n_err    = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        we;
    logic [1:0]  len;
    logic        sign;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
    logic        exp_split;
    int          exp_lat;
    int          exp_strb;
  } vec_t;

  localparam int NV = 15;
  vec_t vecs [NV];

  function automatic vec_t mk(input logic we, input logic [1:0] len, input logic sgn,
                              input logic [31:0] addr, input logic [31:0] wd,
                              input logic [31:0] rd, input logic err, input logic spl,
                              input int lat, input int strb);
    vec_t v;
    v.we = we; v.len = len; v.sign = sgn; v.addr = addr; v.wdata = wd;
    v.exp_rdata = rd; v.exp_err = err; v.exp_split = spl;
    v.exp_lat = lat; v.exp_strb = strb;
    return v;
  endfunction

  task automatic drive_req(input logic we, input logic [1:0] len, input logic sgn,
                           input logic [31:0] addr, input logic [31:0] wd);
    bus_if.req_valid = 1'b1;
    bus_if.req_we    = we;
    bus_if.req_len   = len;
    bus_if.req_sign  = sgn;
    bus_if.req_addr  = addr;
    bus_if.req_wdata = wd;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int s0, lat;
    logic [31:0] held;

    rst = 1'b1;
    bus_if.req_valid  = 1'b0;
    bus_if.req_we     = 1'b0;
    bus_if.req_len    = 2'b00;
    bus_if.req_sign   = 1'b0;
    bus_if.req_addr   = 32'd0;
    bus_if.req_wdata  = 32'd0;
    bus_if.resp_ready = 1'b1;

    vecs[0]  = mk(0, W, 1, 32'h10,       32'h0,        32'h8899AABB, 0, 0, 2, 1);
    vecs[1]  = mk(0, H, 1, 32'h21,       32'h0,        32'hFFFF9234, 0, 1, 4, 2);
    vecs[2]  = mk(0, H, 0, 32'h21,       32'h0,        32'h00009234, 0, 1, 4, 2);
    vecs[3]  = mk(1, W, 0, 32'h3,        32'hDEADBEEF, 32'h0,        0, 1, 4, 4);
    vecs[4]  = mk(0, W, 0, 32'h3,        32'h0,        32'hDEADBEEF, 0, 1, 8, 4);
    vecs[5]  = mk(0, B, 1, 32'h3,        32'h0,        32'hFFFFFFEF, 0, 0, 2, 1);
    vecs[6]  = mk(0, W, 0, 32'hFFE,      32'h0,        32'h0,        1, 0, 1, 0);
    vecs[7]  = mk(0, B, 1, 32'hFFF,      32'h0,        32'hFFFFFF80, 0, 0, 2, 1);
    vecs[8]  = mk(0, B, 0, 32'hFFF,      32'h0,        32'h00000080, 0, 0, 2, 1);
    vecs[9]  = mk(0, W, 0, 32'hFFFFFFFE, 32'h0,        32'h0,        1, 0, 1, 0);
    vecs[10] = mk(0, 2'b11, 0, 32'h20,   32'h0,        32'h0,        1, 0, 1, 0);
    vecs[11] = mk(1, H, 0, 32'h100,      32'h1234ABCD, 32'h0,        0, 0, 1, 1);
    vecs[12] = mk(0, H, 1, 32'h100,      32'h0,        32'hFFFFABCD, 0, 0, 2, 1);
    vecs[13] = mk(0, B, 0, 32'h12,       32'h0,        32'h00000099, 0, 0, 2, 1);
    vecs[14] = mk(1, H, 0, 32'hFFF,      32'h5555,     32'h0,        1, 0, 1, 0);

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst req_ready",  32'(bus_if.req_ready),  32'd1);
    chk("rst resp_valid", 32'(bus_if.resp_valid), 32'd0);
    chk("rst mem_read",   32'(bus_if.mem_read),   32'd0);
    chk("rst mem_write",  32'(bus_if.mem_write),  32'd0);
    chk("rst mem_addr",   bus_if.mem_addr,        32'd0);
    chk("rst resp_rdata", bus_if.resp_rdata,      32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Table-driven transactions
    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      chk("idle req_ready", 32'(bus_if.req_ready), 32'd1);
      drive_req(vecs[i].we, vecs[i].len, vecs[i].sign, vecs[i].addr, vecs[i].wdata);
      s0 = strb_total;
      @(posedge clk);
      #1;
      bus_if.req_valid = 1'b0;
      lat = 0;
      while (!bus_if.resp_valid && lat < 40) begin
        @(posedge clk);
        #1;
        lat++;
      end
      $display("txn %0d we=%0d len=%0d addr=%h rdata=%h err=%0d split=%0d lat=%0d strobes=%0d",
               i, vecs[i].we, vecs[i].len, vecs[i].addr, bus_if.resp_rdata,
               bus_if.resp_err, bus_if.resp_split, lat, strb_total - s0);
      chk("latency",    32'(lat),                 32'(vecs[i].exp_lat));
      chk("resp_rdata", bus_if.resp_rdata,        vecs[i].exp_rdata);
      chk("resp_err",   32'(bus_if.resp_err),     32'(vecs[i].exp_err));
      chk("resp_split", 32'(bus_if.resp_split),   32'(vecs[i].exp_split));
      chk("strobes",    32'(strb_total - s0),     32'(vecs[i].exp_strb));
      if (i == 0) chk("lw mem_len", 32'(log_len[s0[7:0]]), 32'(W));
      if (i == 1) begin
        chk("lh byte0 addr", log_addr[s0[7:0]],         32'h21);
        chk("lh byte1 addr", log_addr[8'(s0 + 1)],      32'h22);
        chk("lh byte len",   32'(log_len[8'(s0 + 1)]),  32'(B));
      end
      if (i == 3) begin
        for (int k = 0; k < 4; k++) begin
          chk("sw byte addr", log_addr[8'(s0 + k)], 32'h3 + 32'(k));
          chk("sw byte data", 32'(log_data[8'(s0 + k)]), 32'(vecs[3].wdata[8*k +: 8]));
          chk("sw mem byte",  32'(tmem[3 + k]),          32'(vecs[3].wdata[8*k +: 8]));
        end
      end
      @(posedge clk);
      #1;
      chk("resp consumed", 32'(bus_if.resp_valid), 32'd0);
    end

    // Handshake: response held while resp_ready is low, new request ignored
    bus_if.resp_ready = 1'b0;
    @(negedge clk);
    drive_req(1'b0, W, 1'b1, 32'h10, 32'h0);
    @(posedge clk);
    #1;
    drive_req(1'b0, B, 1'b0, 32'h12, 32'h0);
    lat = 0;
    while (!bus_if.resp_valid && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk("hs latency", 32'(lat), 32'd2);
    held = bus_if.resp_rdata;
    chk("hs rdata", held, 32'h8899AABB);
    s0 = strb_total;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      $display("hold cycle %0d resp_valid=%0d rdata=%h req_ready=%0d", c,
               bus_if.resp_valid, bus_if.resp_rdata, bus_if.req_ready);
      chk("hs resp_valid held", 32'(bus_if.resp_valid), 32'd1);
      chk("hs rdata stable",    bus_if.resp_rdata,      32'h8899AABB);
      chk("hs req_ready low",   32'(bus_if.req_ready),  32'd0);
    end
    chk("hs no strobes while busy", 32'(strb_total - s0), 32'd0);
    bus_if.req_valid  = 1'b0;
    bus_if.resp_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("hs resp released", 32'(bus_if.resp_valid), 32'd0);
    chk("hs req_ready back", 32'(bus_if.req_ready), 32'd1);
    repeat (3) @(posedge clk);
    #1;
    chk("hs busy req not queued", 32'(strb_total - s0), 32'd0);

    // Reset during byte 2 of a split store to 0x41
    @(negedge clk);
    drive_req(1'b1, W, 1'b0, 32'h41, 32'h11223344);
    @(posedge clk);
    #1;
    bus_if.req_valid = 1'b0;
    chk("rs byte0 write", 32'(bus_if.mem_write), 32'd1);
    @(posedge clk);
    #1;
    chk("rs byte1 addr", bus_if.mem_addr, 32'h42);
    #2;
    rst = 1'b1;
    #1;
    $display("reset mid-store mem_write=%0d req_ready=%0d resp_valid=%0d",
             bus_if.mem_write, bus_if.req_ready, bus_if.resp_valid);
    chk("rs mem_write drop", 32'(bus_if.mem_write),  32'd0);
    chk("rs req_ready",      32'(bus_if.req_ready),  32'd1);
    chk("rs resp_valid",     32'(bus_if.resp_valid), 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("rs byte0 kept",    32'(tmem[12'h041]), 32'h44);
    chk("rs byte1 abandon", 32'(tmem[12'h042]), 32'h00);
    repeat (3) @(posedge clk);
    #1;
    chk("rs no response", 32'(bus_if.resp_valid), 32'd0);
    chk("rs idle",        32'(bus_if.req_ready),  32'd1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
